// File: rtl/key_digit_scanner.sv
// Debounced single-key entry into a four-digit shift register, shown on a
// continuously multiplexed hex seven-segment display with leading blanking.
module key_digit_scanner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        clear,
    output logic [6:0]  display,
    output logic [3:0]  digit_en,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    localparam logic [7:0]  DEB       = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);

    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [3:0]      cand, cand_nxt;
    logic            accept;
    logic            single;
    logic [3:0]      code;
    logic [3:0][3:0] digits;
    logic [2:0]      count;
    logic [15:0]     timer;
    logic [1:0]      idx, idx_nxt;
    logic            wrap;

    function automatic logic [3:0] enc16(input logic [15:0] v);
        enc16 = 4'h0;
        for (int i = 0; i < 16; i++)
            if (v[i]) enc16 = 4'(i);
    endfunction

    // Segment bits are {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign single = (in != 16'h0) && ((in & (in - 16'd1)) == 16'h0);
    assign code   = enc16(in);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (single) begin
                    state_nxt = CONFIRM;
                    cnt_nxt   = 8'd1;
                    cand_nxt  = code;
                end
            end
            CONFIRM: begin
                if (single && code == cand) begin
                    if (cnt + 8'd1 == DEB) begin
                        state_nxt = HELD;
                        cnt_nxt   = 8'd0;
                        accept    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            HELD: begin
                if (in == 16'h0) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = 8'd1;
                end
            end
            RELEASE: begin
                // Any activity during release re-arms HELD without a new key.
                if (in != 16'h0) begin
                    state_nxt = HELD;
                    cnt_nxt   = 8'd0;
                end else if (cnt + 8'd1 == DEB) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cand      <= 4'h0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            key_valid <= accept;
            if (accept) key_code <= cand;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            digits <= '0;
            count  <= 3'd0;
        end else if (accept) begin
            digits <= {digits[2:0], cand};
            if (count != 3'd4) count <= count + 3'd1;
        end
    end

    assign wrap    = (timer == SCAN_LAST);
    assign idx_nxt = wrap ? idx + 2'd1 : idx;

    // Select and segments both come from idx_nxt so they always name the same digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer    <= 16'd0;
            idx      <= 2'd0;
            digit_en <= 4'b0001;
            display  <= 7'h00;
        end else begin
            timer    <= wrap ? 16'd0 : timer + 16'd1;
            idx      <= idx_nxt;
            digit_en <= 4'b0001 << idx_nxt;
            display  <= ({1'b0, idx_nxt} < count) ? seg7(digits[idx_nxt]) : 7'h00;
        end
    end

endmodule

// File: tb/tb_key_digit_scanner.sv
// Self-checking bench for key_digit_scanner: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_key_digit_scanner;

    localparam int D = 4;
    localparam int S = 4;
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] key_in = 16'h0;
    logic [6:0]  display;
    logic [3:0]  digit_en;
    logic        key_valid;
    logic [3:0]  key_code;

    always #5 clk = ~clk;

    key_digit_scanner #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
        .clock(clk), .reset(reset), .in(key_in), .clear(clear),
        .display(display), .digit_en(digit_en), .key_valid(key_valid), .key_code(key_code)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: press = D consecutive samples of one single key, then locked
    // until D consecutive all-zero samples; scan position is pure arithmetic
    // on the number of edges since reset.
    int         pr_run, rel_run, k, m_cnt;
    bit         locked;
    logic [3:0] pr_code;
    logic [3:0] m_dig [4];
    logic       m_kv;
    logic [3:0] m_kc;
    logic [3:0] m_en;
    logic [6:0] m_disp;

    task automatic model_step();
        int idx;
        int ones;
        logic [3:0] code;
        bit acc;
        if (reset) begin
            pr_run = 0; rel_run = 0; locked = 0; pr_code = 4'h0; k = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_kv = 1'b0; m_kc = 4'h0; m_en = 4'b0001; m_disp = 7'h00;
        end else begin
            idx    = ((k + 1) / S) % 4;
            m_en   = 4'(1 << idx);
            m_disp = (idx < m_cnt) ? SEG[m_dig[idx]] : 7'h00;
            k++;
            ones = $countones(key_in);
            code = 4'h0;
            for (int i = 0; i < 16; i++) if (key_in[i]) code = 4'(i);
            acc = 1'b0;
            if (!locked) begin
                if (ones != 1) pr_run = 0;
                else if (pr_run > 0 && code != pr_code) pr_run = 0;
                else begin
                    if (pr_run == 0) pr_code = code;
                    pr_run++;
                    if (pr_run == D) begin
                        acc = 1'b1; locked = 1'b1; rel_run = 0; pr_run = 0;
                    end
                end
            end else begin
                if (key_in == 16'h0) begin
                    rel_run++;
                    if (rel_run == D) locked = 1'b0;
                end else rel_run = 0;
            end
            m_kv = acc;
            if (acc) m_kc = pr_code;
            if (clear) begin
                for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
                m_cnt = 0;
            end else if (acc) begin
                m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0]; m_dig[0] = pr_code;
                if (m_cnt < 4) m_cnt++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("key_valid", 32'(key_valid), 32'(m_kv));
            chk("key_code", 32'(key_code), 32'(m_kc));
            chk("digit_en", 32'(digit_en), 32'(m_en));
            chk("display", 32'(display), 32'(m_disp));
        end
    end

    int pulses, ntick, pulse_at;

    task automatic clr_counts();
        pulses = 0; ntick = 0; pulse_at = -1;
    endtask

    task automatic tick(input logic [15:0] v, input logic c, input logic r);
        key_in = v; clear = c; reset = r;
        @(negedge clk);
        ntick++;
        if (key_valid === 1'b1) begin
            pulses++;
            pulse_at = ntick;
        end
    endtask

    task automatic run(input logic [15:0] v, input logic c, input int n);
        for (int i = 0; i < n; i++) tick(v, c, 1'b0);
    endtask

    task automatic wait_en(input logic [3:0] e);
        for (int i = 0; i < 20 && digit_en !== e; i++) tick(16'h0, 1'b0, 1'b0);
        chk("scan_reach", 32'(digit_en), 32'(e));
    endtask

    initial begin
        logic [3:0] rot [4];
        logic [6:0] lit [4];
        logic [15:0] v;
        int n, r, len;
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        lit = '{7'h6D, 7'h66, 7'h4F, 7'h5B};

        @(negedge clk);
        tick(16'h0, 1'b0, 1'b1);
        tick(16'h0, 1'b0, 1'b1);
        chk_on = 1'b1;
        chk("rst_display", 32'(display), 32'h00);
        chk("rst_digit_en", 32'(digit_en), 32'h1);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);

        for (int j = 1; j <= 16; j++) begin
            tick(16'h0, 1'b0, 1'b0);
            if (j % 4 == 0) chk("scan_rotate", 32'(digit_en), 32'(rot[j/4 - 1]));
        end

        clr_counts(); run(16'h0020, 1'b0, 10);
        chk("press_pulses", pulses, 1);
        chk("press_latency", pulse_at, 4);
        chk("press_code", 32'(key_code), 32'h5);
        run(16'h0, 1'b0, 5);
        wait_en(4'b0001);
        chk("one_digit_lit", 32'(display), 32'h6D);
        wait_en(4'b0010);
        chk("leading_blank", 32'(display), 32'h00);

        clr_counts(); run(16'h0020, 1'b0, 3);
        chk("bounce_none", pulses, 0);
        run(16'h0, 1'b0, 1); run(16'h0020, 1'b0, 4);
        chk("bounce_one", pulses, 1);
        chk("bounce_at", pulse_at, 8);
        run(16'h0, 1'b0, 5);

        clr_counts(); run(16'h0021, 1'b0, 10);
        chk("multi_none", pulses, 0);
        run(16'h0001, 1'b0, 4);
        chk("multi_then_one", pulse_at, 14);
        chk("multi_code", 32'(key_code), 32'h0);
        run(16'h0, 1'b0, 5);

        clr_counts(); run(16'h0008, 1'b0, 3); tick(16'h0008, 1'b0, 1'b1); run(16'h0008, 1'b0, 3);
        chk("rst_discard", pulses, 0);
        run(16'h0008, 1'b0, 1);
        chk("rst_repress", pulses, 1);
        chk("rst_code", 32'(key_code), 32'h3);
        run(16'h0, 1'b0, 5);

        run(16'h0, 1'b1, 1);
        clr_counts();
        for (int kk = 1; kk <= 5; kk++) begin
            run(16'(1 << kk), 1'b0, 5);
            run(16'h0, 1'b0, 5);
        end
        chk("five_pulses", pulses, 5);
        chk("five_code", 32'(key_code), 32'h5);
        for (int i = 0; i < 4; i++) begin
            wait_en(4'(1 << i));
            chk("four_digits", 32'(display), 32'(lit[i]));
        end

        clr_counts(); run(16'h0400, 1'b0, 20); run(16'h0, 1'b0, 2);
        run(16'h0400, 1'b0, 1); run(16'h0, 1'b0, 5);
        chk("hold_single", pulses, 1);
        chk("hold_code", 32'(key_code), 32'hA);

        clr_counts(); run(16'h0080, 1'b0, 3); run(16'h0080, 1'b1, 1);
        chk("clr_acc_pulse", 32'(key_valid), 32'h1);
        chk("clr_acc_code", 32'(key_code), 32'h7);
        run(16'h0080, 1'b0, 2); run(16'h0, 1'b0, 5);
        for (int i = 0; i < 16; i++) begin
            tick(16'h0, 1'b0, 1'b0);
            chk("clr_acc_blank", 32'(display), 32'h00);
        end

        n = 0;
        while (n < 4000) begin
            r   = $urandom_range(0, 99);
            len = $urandom_range(1, 9);
            if (r < 45)      v = 16'(1 << $urandom_range(0, 15));
            else if (r < 70) v = 16'h0;
            else if (r < 82) v = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            else             v = 16'($urandom);
            for (int i = 0; i < len; i++)
                tick(v, ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
            n += len;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_digit_scanner.md
KEY_DIGIT_SCANNER -- requirements
Module: key_digit_scanner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable samples needed to accept a press or a release (legal 2..255).
REQ-002 Parameter SCAN_CYCLES, default 4, SHALL set the clock cycles each digit stays enabled (legal 1..65535).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 in  input  16  SHALL carry the raw key lines, active-high, one bit per key 0..F.
REQ-006 clear  input  1  SHALL be a synchronous request to erase all entered digits.
REQ-007 display  output  7  SHALL carry the segment pattern of the selected digit, registered, in the team's standard hex seven-segment encoding.
REQ-008 digit_en  output  4  SHALL be the one-hot digit select, registered, active-high, bit 0 = rightmost digit.
REQ-009 key_valid  output  1  SHALL be a one-cycle registered pulse marking an accepted key.
REQ-010 key_code  output  4  SHALL hold the code of the last accepted key, registered.

Function
REQ-011 A sample SHALL count as "single" only when exactly one bit of in is set; the code is that bit's index, produced by the team's standard 16-to-4 encoder.
REQ-012 Debounce FSM states SHALL be IDLE, CONFIRM, HELD and RELEASE, with an 8-bit counter cnt.
REQ-013 IDLE: single sample -> CONFIRM, cnt=1, candidate=code; zero or multi-key sample -> stay in IDLE.
REQ-014 CONFIRM: single sample with the same code -> cnt+1; any other sample (zero, multi-key, different code) -> IDLE.
REQ-015 CONFIRM: at the edge where cnt would reach DEBOUNCE_CYCLES -> HELD, with the following on that same edge: key_valid=1, key_code=candidate, candidate shifted into the digit register.
REQ-016 HELD: in nonzero -> stay, no further pulses; in==0 -> RELEASE, cnt=1.
REQ-017 RELEASE: in==0 -> cnt+1; at DEBOUNCE_CYCLES -> IDLE; any nonzero sample -> HELD with no new pulse.
REQ-018 Press latency: key_valid SHALL go high after the DEBOUNCE_CYCLES-th consecutive rising edge that samples the same single key.
REQ-019 Digit register: four 4-bit digits d3..d0; on accept, d3<=d2, d2<=d1, d1<=d0, d0<=candidate; the oldest digit is discarded.
REQ-020 Digit count: 3-bit count of entered digits, incremented on each accept and saturating at 4; no overflow flag.
REQ-021 clear SHALL zero d3..d0 and count on the next edge.
REQ-022 When clear and an accept occur on the same edge, clear SHALL win for digits and count; key_valid and key_code SHALL still update; the FSM is unaffected by clear.
REQ-023 Scan timer SHALL count 0..SCAN_CYCLES-1 and wrap.
REQ-024 On each scan-timer wrap, the 2-bit digit index SHALL advance mod 4 (3 -> 0).
REQ-025 digit_en SHALL be the one-hot of the digit index.
REQ-026 display SHALL be the decoded d[index] when index < count, otherwise 7'b0000000 (leading blanking).
REQ-027 display and digit_en SHALL be registered on the same edge, so they never refer to different digits.
REQ-028 A digit change from an accept or a clear SHALL appear on display no later than one cycle after the register update.
REQ-029 The scan SHALL run continuously, independent of the FSM, of clear and of key activity.

Reset
REQ-030 On reset: FSM=IDLE, cnt=0, candidate=0, d3..d0=0, count=0, scan timer=0, index=0.
REQ-031 On reset: digit_en=4'b0001, display=7'b0000000, key_valid=0, key_code=4'h0.
REQ-032 Reset SHALL override clear and in; a press in progress SHALL be discarded and need a full new debounce after reset deasserts.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=4)
REQ-033 Reset 2 cycles, in=0 -> display=0, digit_en=0001, key_valid=0, and digit_en rotates 0001->0010->0100->1000->0001 every 4 cycles.
REQ-034 in=16'h0020 held 10 cycles -> exactly one key_valid pulse, on the 4th edge; key_code=5, d0=5, count=1; display shows "5" only while digit_en=0001 and is 0 for the other digits.
REQ-035 Bounce: in=16'h0020 for 3 cycles, 0 for 1, then 16'h0020 for 4 cycles -> no pulse after the first burst, one pulse on the 4th edge of the second burst.
REQ-036 Multi-key: in=16'h0021 for 10 cycles -> no key_valid; then in=0x0001 for 4 cycles -> pulse with key_code=0.
REQ-037 Enter keys 1,2,3,4,5, each pressed 5 cycles and released 5 cycles -> five pulses; digits d3..d0=2,3,4,5, count=4, all four digits lit.
REQ-038 Hold 4'hA for 20 cycles, 2 cycles of 0, 1 cycle of nonzero, then release 5 cycles -> a single pulse.
REQ-039 clear asserted on the same edge as an accept -> key_valid=1 and key_code updated, but d3..d0=0, count=0 and display blank.
